kgp_reg_exec: RTL and testbench

Register-bank execution controller sitting directly upstream of the KGP ALU. It accepts one instruction at a time over a valid/ready handshake and reads two source operands from an internal 16x32 register bank. It drives the ALU's `operand1`/`operand2`/`command` inputs, captures the ALU result `z`, and writes it back to the destination register, with divide-by-zero and illegal-command detection.

---
 rtl/kgp_alu_pkg.sv | 32 +++
 rtl/kgp_reg_exec_reg_file.sv | 38 +++
 rtl/kgp_reg_exec.sv | 150 +++++++++++++++
 tb/tb_kgp_reg_exec.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_alu_pkg.sv
// Shared definitions for the KGP ALU and its register-bank execution
// controller: command codes, register-bank geometry and FSM encoding.
package kgp_alu_pkg;

  localparam int NREG   = 16;
  localparam int ADDR_W = 4;

  localparam logic [3:0] CMD_ADD   = 4'd0;
  localparam logic [3:0] CMD_SUB   = 4'd1;
  localparam logic [3:0] CMD_MUL   = 4'd2;
  localparam logic [3:0] CMD_DIV   = 4'd3;
  localparam logic [3:0] CMD_AND   = 4'd4;
  localparam logic [3:0] CMD_OR    = 4'd5;
  localparam logic [3:0] CMD_XOR   = 4'd6;
  localparam logic [3:0] CMD_NOT   = 4'd7;
  localparam logic [3:0] CMD_PASS1 = 4'd8;
  localparam logic [3:0] CMD_PASS2 = 4'd9;
  localparam logic [3:0] CMD_SLL   = 4'd10;
  localparam logic [3:0] CMD_SRL   = 4'd11;
  localparam logic [3:0] CMD_SRA   = 4'd12;
  localparam logic [3:0] CMD_ADD4  = 4'd13;
  localparam logic [3:0] CMD_SUB4  = 4'd14;
  localparam logic [3:0] CMD_HAM   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } exec_state_t;

endpackage

// File: rtl/kgp_reg_exec_reg_file.sv
// 16-entry register bank: two combinational operand read ports, a
// combinational debug read port and one synchronous write port.
// R0 is hardwired to zero; writes addressed to it are dropped.
module reg_file_16x32
  import kgp_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NREG];

  // Storage: cleared asynchronously, written on the rising edge except to R0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports force R0 to zero regardless of storage contents.
  assign rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/kgp_reg_exec.sv
// Register-bank execution controller in front of the KGP ALU. Runs one
// instruction every four cycles: accept, read operands, execute (capture
// ALU result and classify errors), write back.
module kgp_reg_exec
  import kgp_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cmd,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_imm_sel,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [3:0]        alu_cmd,
  input  logic [DATA_W-1:0] alu_z,
  output logic              done_valid,
  output logic [ADDR_W-1:0] done_rd,
  output logic [DATA_W-1:0] done_data,
  output logic              err_div0,
  output logic              err_illegal,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  exec_state_t       state;
  logic              ready_q;
  logic [3:0]        cmd_q;
  logic [ADDR_W-1:0] rs_q;
  logic [ADDR_W-1:0] rt_q;
  logic [ADDR_W-1:0] rd_q;
  logic              imm_sel_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic [DATA_W-1:0] res_q;
  logic              done_valid_q;
  logic [ADDR_W-1:0] done_rd_q;
  logic [DATA_W-1:0] done_data_q;
  logic              err_div0_q;
  logic              err_illegal_q;

  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;
  logic              div0_now;
  logic              illegal_now;
  logic              wr_en;

  reg_file_16x32 #(.DATA_W(DATA_W)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr1 (rs_q),
    .rd_data1 (rf_rd1),
    .rd_addr2 (rt_q),
    .rd_data2 (rf_rd2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_en    (wr_en),
    .wr_addr  (rd_q),
    .wr_data  (res_q)
  );

  // Error classification from the latched command and operand, used in EXEC.
  always_comb begin
    div0_now    = 1'b0;
    illegal_now = 1'b0;
    if ((cmd_q == CMD_DIV) && (op2_q == '0)) div0_now = 1'b1;
    if (cmd_q == CMD_HAM) illegal_now = 1'b1;
  end

  // Writeback happens at the end of WB; R0 is filtered inside the bank.
  assign wr_en = (state == ST_WB) && !err_div0_q && !err_illegal_q;

  // Main sequencer: IDLE -> READ -> EXEC -> WB -> IDLE with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ready_q       <= 1'b1;
      cmd_q         <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rd_q          <= '0;
      imm_sel_q     <= 1'b0;
      imm_q         <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      res_q         <= '0;
      done_valid_q  <= 1'b0;
      done_rd_q     <= '0;
      done_data_q   <= '0;
      err_div0_q    <= 1'b0;
      err_illegal_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && ready_q) begin
            cmd_q     <= in_cmd;
            rs_q      <= in_rs;
            rt_q      <= in_rt;
            rd_q      <= in_rd;
            imm_sel_q <= in_imm_sel;
            imm_q     <= in_imm;
            ready_q   <= 1'b0;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          op1_q <= rf_rd1;
          op2_q <= imm_sel_q ? imm_q : rf_rd2;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q         <= alu_z;
          done_valid_q  <= 1'b1;
          done_rd_q     <= rd_q;
          done_data_q   <= (div0_now || illegal_now) ? '0 : alu_z;
          err_div0_q    <= div0_now;
          err_illegal_q <= illegal_now;
          state         <= ST_WB;
        end
        ST_WB: begin
          done_valid_q <= 1'b0;
          ready_q      <= 1'b1;
          state        <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = ready_q;
  assign alu_op1     = op1_q;
  assign alu_op2     = op2_q;
  assign alu_cmd     = cmd_q;
  assign done_valid  = done_valid_q;
  assign done_rd     = done_rd_q;
  assign done_data   = done_data_q;
  assign err_div0    = err_div0_q;
  assign err_illegal = err_illegal_q;

endmodule

// File: tb/tb_kgp_reg_exec.sv
// Bench for kgp_reg_exec: behavioural ALU attached to the ALU ports, a
// register-array reference model, directed scenarios then random traffic.
module tb_kgp_reg_exec;
  import kgp_alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cmd;
  logic [3:0]  in_rs;
  logic [3:0]  in_rt;
  logic [3:0]  in_rd;
  logic        in_imm_sel;
  logic [31:0] in_imm;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_z;
  logic        done_valid;
  logic [3:0]  done_rd;
  logic [31:0] done_data;
  logic        err_div0;
  logic        err_illegal;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  int tests;
  int fails;
  logic [31:0] model [16];

  kgp_reg_exec #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cmd      (in_cmd),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_imm_sel  (in_imm_sel),
    .in_imm      (in_imm),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_cmd     (alu_cmd),
    .alu_z       (alu_z),
    .done_valid  (done_valid),
    .done_rd     (done_rd),
    .done_data   (done_data),
    .err_div0    (err_div0),
    .err_illegal (err_illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural KGP ALU; divide by zero yields all ones so the block must mask it.
  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    case (c)
      CMD_ADD:   return a + b;
      CMD_SUB:   return a - b;
      CMD_MUL:   return a * b;
      CMD_DIV:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      CMD_AND:   return a & b;
      CMD_OR:    return a | b;
      CMD_XOR:   return a ^ b;
      CMD_NOT:   return ~a;
      CMD_PASS1: return a;
      CMD_PASS2: return b;
      CMD_SLL:   return a << b[4:0];
      CMD_SRL:   return a >> b[4:0];
      CMD_SRA:   return $unsigned($signed(a) >>> b[4:0]);
      CMD_ADD4:  return a + 32'd4;
      CMD_SUB4:  return a - 32'd4;
      default:   return 32'($countones(a));
    endcase
  endfunction

  always_comb alu_z = alu_f(alu_cmd, alu_op1, alu_op2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    in_cmd     = 4'($urandom);
    in_rs      = 4'($urandom);
    in_rt      = 4'($urandom);
    in_rd      = 4'($urandom);
    in_imm_sel = 1'($urandom);
    in_imm     = $urandom;
  endtask

  // One full instruction with cycle-exact checks; hold keeps in_valid high
  // with garbage on in_* during the busy cycles.
  task automatic run_instr(input logic [3:0] cmd, input logic [3:0] rs, input logic [3:0] rt,
                           input logic [3:0] rd, input logic isel, input logic [31:0] imm,
                           input bit hold);
    logic [31:0] op1, op2, z, exp_data;
    bit div0, ill, wr;
    op1      = model[rs];
    op2      = isel ? imm : model[rt];
    z        = alu_f(cmd, op1, op2);
    div0     = (cmd == 4'd3) && (op2 == 32'd0);
    ill      = (cmd == 4'd15);
    exp_data = (div0 || ill) ? 32'd0 : z;
    wr       = !div0 && !ill && (rd != 4'd0);

    @(negedge clk);
    chk("ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_cmd = cmd; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm_sel = isel; in_imm = imm;
    @(posedge clk); #1;
    in_valid = hold;
    scramble();
    chk("ready_read", {31'd0, in_ready}, 32'd0);
    chk("done_read", {31'd0, done_valid}, 32'd0);
    @(posedge clk); #1;
    scramble();
    dbg_addr = rd;
    chk("alu_op1", alu_op1, op1);
    chk("alu_op2", alu_op2, op2);
    chk("alu_cmd", {28'd0, alu_cmd}, {28'd0, cmd});
    chk("ready_exec", {31'd0, in_ready}, 32'd0);
    chk("done_exec", {31'd0, done_valid}, 32'd0);
    @(posedge clk); #1;
    scramble();
    chk("done_valid", {31'd0, done_valid}, 32'd1);
    chk("done_rd", {28'd0, done_rd}, {28'd0, rd});
    chk("done_data", done_data, exp_data);
    chk("err_div0", {31'd0, err_div0}, {31'd0, div0});
    chk("err_illegal", {31'd0, err_illegal}, {31'd0, ill});
    chk("dbg_old_wb", dbg_data, model[rd]);
    chk("ready_wb", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (wr) model[rd] = z;
    chk("done_cleared", {31'd0, done_valid}, 32'd0);
    chk("ready_back", {31'd0, in_ready}, 32'd1);
    chk("dbg_new", dbg_data, model[rd]);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_op1"}, alu_op1, 32'd0);
    chk({tag, "_op2"}, alu_op2, 32'd0);
    chk({tag, "_cmd"}, {28'd0, alu_cmd}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_valid}, 32'd0);
    chk({tag, "_drd"}, {28'd0, done_rd}, 32'd0);
    chk({tag, "_ddata"}, done_data, 32'd0);
    chk({tag, "_div0"}, {31'd0, err_div0}, 32'd0);
    chk({tag, "_ill"}, {31'd0, err_illegal}, 32'd0);
  endtask

  task automatic check_bank(input string tag);
    for (int r = 0; r < 16; r++) begin
      dbg_addr = 4'(r);
      #1;
      chk(tag, dbg_data, model[r]);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int r = 0; r < 16; r++) model[r] = 32'd0;
    rst_n = 1'b0; in_valid = 1'b0; in_cmd = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_imm_sel = 1'b0; in_imm = '0; dbg_addr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_cleared("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    check_bank("rst_bank");

    // ADD-immediate loads then register ADD
    run_instr(CMD_ADD, 4'd0, 4'd0, 4'd1, 1'b1, 32'd5, 1'b0);
    run_instr(CMD_ADD, 4'd0, 4'd0, 4'd2, 1'b1, 32'd7, 1'b0);
    run_instr(CMD_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0, 1'b0);
    chk("r3_is_12", model[3], 32'd12);

    // Divide by zero, illegal command, write to R0
    run_instr(CMD_ADD, 4'd0, 4'd0, 4'd4, 1'b1, 32'd100, 1'b0);
    run_instr(CMD_DIV, 4'd4, 4'd0, 4'd5, 1'b1, 32'd0, 1'b0);
    run_instr(CMD_HAM, 4'd4, 4'd1, 4'd6, 1'b0, 32'd0, 1'b0);
    run_instr(CMD_ADD4, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 1'b0);
    run_instr(CMD_DIV, 4'd4, 4'd1, 4'd10, 1'b0, 32'd0, 1'b0);

    // Back-to-back dependency, SUB then SRA
    run_instr(CMD_SUB, 4'd1, 4'd2, 4'd7, 1'b0, 32'd0, 1'b0);
    run_instr(CMD_SRA, 4'd7, 4'd0, 4'd8, 1'b1, 32'd1, 1'b0);
    chk("r7_sub", model[7], 32'hFFFF_FFFE);
    chk("r8_sra", model[8], 32'hFFFF_FFFF);

    // in_valid held high through busy periods with changing in_*
    run_instr(CMD_MUL, 4'd3, 4'd4, 4'd11, 1'b0, 32'd0, 1'b1);
    run_instr(CMD_XOR, 4'd11, 4'd0, 4'd12, 1'b1, 32'hA5A5_0F0F, 1'b1);
    run_instr(CMD_SLL, 4'd12, 4'd0, 4'd13, 1'b1, 32'd35, 1'b1);

    // Random traffic
    for (int i = 0; i < 48; i++) begin
      logic [31:0] imm;
      imm = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_instr(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                1'($urandom), imm, bit'($urandom_range(0, 1)));
    end
    check_bank("bank_rand");

    // Reset during EXEC of a MUL into R9
    run_instr(CMD_ADD, 4'd0, 4'd0, 4'd1, 1'b1, 32'd3, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_cmd = CMD_MUL; in_rs = 4'd1; in_rt = 4'd1; in_rd = 4'd9;
    in_imm_sel = 1'b0; in_imm = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("exec_cmd_mul", {28'd0, alu_cmd}, {28'd0, CMD_MUL});
    rst_n = 1'b0;
    #1;
    for (int r = 0; r < 16; r++) model[r] = 32'd0;
    check_cleared("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", {31'd0, done_valid}, 32'd0);
      chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    end
    check_bank("midrst_bank");

    // Operation resumes after reset
    run_instr(CMD_ADD4, 4'd0, 4'd0, 4'd9, 1'b0, 32'd0, 1'b0);
    run_instr(CMD_PASS2, 4'd9, 4'd0, 4'd14, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check_bank("final_bank");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
